load_store_unit: RTL and testbench

//  Data-memory access stage directly downstream of the ALU: takes the ALU Result as the effective address,

---
 rtl/load_store_unit_pkg.sv | 19 +
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e : access FSM states (IDLE, REQ, WAIT, DONE)
//   LSU_*       : funct3 access-size encodings carried on lsu_size
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   size_i     : funct3 access size
//   off_i      : Addr[1:0], byte offset within the word
//   wdata_i    : store data (rs2)
//   rdata_i    : raw word returned by memory
//   be_o       : byte enables for the bus
//   wdata_o    : store data replicated across all lanes
//   rdata_o    : selected lane, sign/zero-extended per size
//   misalign_o : access is misaligned or the size code is illegal
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rdata_i[{off_i, 3'b000} +: 8];
        half_lane  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o       = '0;
        wdata_o    = wdata_i;
        rdata_o    = '0;
        misalign_o = 1'b0;
        case (size_i)
            LSU_B, LSU_BU: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (size_i == LSU_B) ? {{24{byte_lane[7]}}, byte_lane}
                                            : {24'b0, byte_lane};
            end
            LSU_H, LSU_HU: begin
                misalign_o = off_i[0];
                be_o       = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = (size_i == LSU_H) ? {{16{half_lane[15]}}, half_lane}
                                               : {16'b0, half_lane};
            end
            LSU_W: begin
                misalign_o = |off_i;
                be_o       = 4'b1111;
                rdata_o    = rdata_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access per instruction over a
// req/gnt/rvalid bus, using the ALU result as the effective address.
//   clk, rst              : clock, asynchronous active-low reset
//   lsu_valid/we/size     : access request from the core, held until lsu_done
//   Addr, WData           : byte address and store data
//   RData                 : formatted load data, held until the next completed load
//   lsu_done              : one-cycle completion pulse
//   stall                 : lsu_valid & ~lsu_done
//   misalign, bus_err     : completion status, valid with lsu_done
//   mem_req/we/addr/be/wdata, mem_gnt, mem_rvalid, mem_rdata : memory bus
// Optional watchdog: define LSU_TIMEOUT_EN to abort a WAIT lasting TIMEOUT
// cycles with bus_err; otherwise WAIT is unbounded and bus_err is tied 0.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_size,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        lsu_done,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("TIMEOUT must be within 1..255");
    end

    lsu_state_e  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_mis;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       bus_err_q, bus_err_d;
`endif

    // Size/offset come straight from the request inputs, which the core
    // holds stable until lsu_done, so load formatting in WAIT is still valid.
    lsu_align u_align (
        .size_i     (lsu_size),
        .off_i      (Addr[1:0]),
        .wdata_i    (WData),
        .rdata_i    (mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
            tmo_q       <= tmo_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
        tmo_d       = tmo_q;
        bus_err_d   = bus_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (lsu_valid) begin
                    if (al_mis) begin
                        state_d    = ST_DONE;
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lsu_we;
                        mem_addr_d  = {Addr[31:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d   = ST_WAIT;
                    mem_req_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                end
            end
            ST_WAIT: begin
                // A response arriving in the expiry cycle still completes normally.
                if (mem_rvalid) begin
                    state_d = ST_DONE;
                    if (!lsu_we) begin
                        rdata_d = al_rdata;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_DONE;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                misalign_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
                bus_err_d  = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign RData     = rdata_q;
    assign lsu_done  = (state_q == ST_DONE);
    assign stall     = lsu_valid & ~lsu_done;
    assign misalign  = misalign_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_we;
    logic [2:0]  lsu_size;
    logic [31:0] Addr, WData, RData;
    logic        lsu_done, stall, misalign, bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_valid  (lsu_valid),
        .lsu_we     (lsu_we),
        .lsu_size   (lsu_size),
        .Addr       (Addr),
        .WData      (WData),
        .RData      (RData),
        .lsu_done   (lsu_done),
        .stall      (stall),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        logic        misalign;
        logic        bus_err;
        int unsigned lat;
        int unsigned req_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] last_rd = '0;
    time         t_start = 0;

    // bus responder controls
    int unsigned gnt_dly = 0;
    logic        resp_en = 1'b1;
    logic [31:0] resp_rdata = '0;
    logic        stale_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model: byte-wise view of the access, independent of lane muxing.
    function automatic exp_t model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd,
                                   input int unsigned gd, input logic rsp);
        exp_t        e;
        int unsigned nb, off;
        logic        ill;
        logic [31:0] sh, v;
        off = a[1:0];
        case (sz[1:0])
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            2'd2:    nb = 4;
            default: nb = 0;
        endcase
        ill = (nb == 0) || (sz == 3'b110);
        e.misalign = ill || ((off % (nb == 0 ? 1 : nb)) != 0);
        e.addr = {a[31:2], 2'b00};
        e.we   = we;
        e.be   = '0;
        e.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            e.be[i] = (i >= off) && (i < off + nb);
            if (nb != 0) e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        sh = rd >> (8 * off);
        if (nb == 1)      v = sz[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        else if (nb == 2) v = sz[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else              v = rd;
        e.bus_err = 1'b0;
        e.rdata   = last_rd;
        if (e.misalign) begin
            e.lat = 2; e.req_cyc = 0;
        end else if (!rsp) begin
            e.bus_err = 1'b1; e.lat = TMO + 3; e.req_cyc = gd + 1;
        end else begin
            e.lat = 4 + gd; e.req_cyc = gd + 1;
            if (!we) e.rdata = v;
        end
        return e;
    endfunction

    // Memory responder: grants after gnt_dly request cycles, responds one cycle later.
    initial begin
        int unsigned req_cnt;
        logic        pend;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        req_cnt = 0; pend = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (!rst) begin
                req_cnt = 0; pend = 1'b0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (resp_en) begin mem_rvalid = 1'b1; mem_rdata = resp_rdata; end
                end else if (stale_req) begin
                    mem_rvalid = 1'b1; mem_rdata = 32'hBADC0DE5;
                end
                if (mem_req) begin
                    req_cnt++;
                    if (req_cnt > gnt_dly) begin mem_gnt = 1'b1; pend = 1'b1; req_cnt = 0; end
                end else begin
                    req_cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor: checks bus request fields and completion results.
    initial begin
        int unsigned req_cycles;
        logic        req_seen;
        exp_t        e;
        time         dt;
        req_cycles = 0; req_seen = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                req_cycles = 0; req_seen = 1'b0;
            end else begin
                if (mem_req) begin
                    if (sb.size() == 0) begin
                        check("unexpected_req", 32'(mem_req), 32'd0);
                    end else if (!req_seen) begin
                        check("mem_addr", mem_addr, sb[0].addr);
                        check("mem_be", 32'(mem_be), 32'(sb[0].be));
                        check("mem_we", 32'(mem_we), 32'(sb[0].we));
                        if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
                        check("stall_req", 32'(stall), 32'd1);
                    end
                    req_seen = 1'b1;
                    req_cycles++;
                end
                if (lsu_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(lsu_done), 32'd0);
                    end else begin
                        e  = sb.pop_front();
                        dt = $time - t_start;
                        check("RData", RData, e.rdata);
                        check("misalign", 32'(misalign), 32'(e.misalign));
                        check("bus_err", 32'(bus_err), 32'(e.bus_err));
                        check("latency", 32'((dt + 4) / 10 + 1), 32'(e.lat));
                        check("req_cycles", 32'(req_cycles), 32'(e.req_cyc));
                        check("stall_done", 32'(stall), 32'd0);
                    end
                    req_cycles = 0; req_seen = 1'b0;
                end
            end
        end
    end

    task automatic start_access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int unsigned gd, input logic rsp);
        exp_t e;
        e = model(we, sz, a, wd, rd, gd, rsp);
        if (!e.misalign && !e.bus_err && !we) last_rd = e.rdata;
        @(negedge clk);
        gnt_dly = gd; resp_rdata = rd; resp_en = rsp;
        lsu_we = we; lsu_size = sz; Addr = a; WData = wd;
        sb.push_back(e);
        t_start = $time;
        lsu_valid = 1'b1;
    endtask

    task automatic wait_done(input int unsigned budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (lsu_done) begin got = 1'b1; break; end
        end
        if (!got) check("done_wait", 32'd0, 32'd1);
        lsu_valid = 1'b0;
    endtask

    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int unsigned gd);
        start_access(we, sz, a, wd, rd, gd, 1'b1);
        wait_done(60);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_RData"}, RData, 32'h0);
        check({tag, "_done"}, 32'(lsu_done), 32'd0);
        check({tag, "_misalign"}, 32'(misalign), 32'd0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; lsu_valid = 1'b0;
        sb.delete();
        last_rd = '0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [2:0]  sizes [7];
        logic [31:0] rw, dw;
        rst = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_size = '0; Addr = '0; WData = '0;
        sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        check("init_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // directed cases
        access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw_RData", RData, 32'hDEAD_BEEF);
        access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0);
        check("lb_RData", RData, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0);
        check("lbu_RData", RData, 32'h0000_0080);
        access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 3);
        check("sh_RData_kept", RData, 32'h0000_0080);
        access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_1111, 0);
        access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h2222_2222, 0);
        check("mis_RData_kept", RData, 32'h0000_0080);

        // sweep of sizes and offsets
        for (int s = 0; s < 7; s++) begin
            for (int o = 0; o < 4; o++) begin
                rw = $urandom; dw = $urandom;
                access(logic'((s + o) % 2), sizes[s], 32'h0000_1000 + 32'(16 * s + o), dw, rw,
                       $urandom_range(0, 2));
            end
        end

        // reset while waiting for the response, then a stale rvalid
        start_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("wait_mem_req", 32'(mem_req), 32'd0);
        check("wait_stall", 32'(stall), 32'd1);
        do_reset();
        @(negedge clk); stale_req = 1'b1;
        @(negedge clk); stale_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stale_done", 32'(lsu_done), 32'd0);
            check("stale_RData", RData, 32'h0);
            check("stale_mem_req", 32'(mem_req), 32'd0);
        end

        // no response: watchdog or indefinite stall
`ifdef LSU_TIMEOUT_EN
        start_access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h7777_7777, 0, 1'b0);
        wait_done(60);
        check("tmo_RData", RData, 32'h0);
`else
        start_access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h7777_7777, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hang_stall", 32'(stall), 32'd1);
            check("hang_done", 32'(lsu_done), 32'd0);
        end
        do_reset();
`endif
        resp_en = 1'b1;
        access(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0123_4567, 1);
        check("final_RData", RData, 32'h0123_4567);
        check("sb_empty", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
